mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_pkg.sv | 28 ++
 rtl/mem_access_unit_if.sv | 32 +++
 rtl/mem_lane_align.sv | 48 ++++
 rtl/mem_access_unit.sv | 251 +++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types for the load/store unit: access size, FSM states and AXI response codes.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_t;

  typedef enum logic [2:0] {
    IDLE,
    RAM,
    AXI_AW_W,
    AXI_B,
    AXI_AR,
    AXI_R,
    DONE
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic misaligned(size_t sz, logic [1:0] off);
    return (sz == SZ_RSVD) || (sz == SZ_HALF && off[0]) || (sz == SZ_WORD && off != 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// AXI-lite master bus of the load/store unit (read and write channels).
interface mem_access_unit_if;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arprot, arvalid, rready, awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arprot, arvalid, rready, awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store replication/strobe and load extract/extend.
module mem_lane_align
  import mem_pkg::*;
(
  input  size_t       st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_wdata_i,
  output logic [31:0] st_data_o,
  output logic [3:0]  st_strb_o,
  input  size_t       ld_size_i,
  input  logic        ld_unsigned_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] ld_shift;

  always_comb begin
    st_data_o = st_wdata_i;
    st_strb_o = 4'b1111;
    case (st_size_i)
      SZ_BYTE: begin
        st_data_o = {4{st_wdata_i[7:0]}};
        st_strb_o = 4'b0001 << st_off_i;
      end
      SZ_HALF: begin
        st_data_o = {2{st_wdata_i[15:0]}};
        st_strb_o = 4'b0011 << st_off_i;
      end
      default: ;
    endcase
  end

  // Selected lane is moved down to bit 0 before extension.
  always_comb begin
    ld_shift  = ld_word_i >> {ld_off_i, 3'b000};
    ld_data_o = ld_word_i;
    case (ld_size_i)
      SZ_BYTE: ld_data_o = ld_unsigned_i ? {24'h0, ld_shift[7:0]}
                                         : {{24{ld_shift[7]}}, ld_shift[7:0]};
      SZ_HALF: ld_data_o = ld_unsigned_i ? {16'h0, ld_shift[15:0]}
                                         : {{16{ld_shift[15]}}, ld_shift[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: routes aligned accesses to a fixed-latency RAM or an AXI-lite
// peripheral window, with per-phase timeout and a one-cycle done pulse.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int         RAM_AW   = 19,
  parameter int         RAM_LAT  = 1,
  parameter logic [7:0] MMIO_TAG = 8'h7F,
  parameter int         TIMEOUT  = 1024
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_load,
  input  logic              req_store,
  input  size_t             req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              done,
  output logic              fault,
  output logic [31:0]       rdata,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_dina,
  input  logic [31:0]       ram_douta,
  output logic              ram_ena,
  output logic [3:0]        ram_wea,
  mem_access_unit_if.master m_axi
);

  localparam int CW = $clog2(TIMEOUT + 8);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              fault_q, fault_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       ram_dina_q, ram_dina_d;
  logic              ram_ena_q, ram_ena_d;
  logic [3:0]        ram_wea_q, ram_wea_d;
  logic [31:0]       axi_addr_q, axi_addr_d;
  logic              arvalid_q, arvalid_d, rready_q, rready_d;
  logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  size_t             ld_size_q;
  logic              ld_uns_q;
  logic [1:0]        ld_off_q;
  logic [31:0]       st_data, ld_data, ld_word;
  logic [3:0]        st_strb;
  logic              accept, tmo_hit;

  assign accept  = (state_q == IDLE) && req_valid;
  assign tmo_hit = (cnt_q == CW'(TIMEOUT - 1));
  assign ld_word = (state_q == RAM) ? ram_douta : m_axi.rdata;

  mem_lane_align u_align (
    .st_size_i    (req_size),
    .st_off_i     (req_addr[1:0]),
    .st_wdata_i   (req_wdata),
    .st_data_o    (st_data),
    .st_strb_o    (st_strb),
    .ld_size_i    (ld_size_q),
    .ld_unsigned_i(ld_uns_q),
    .ld_off_i     (ld_off_q),
    .ld_word_i    (ld_word),
    .ld_data_o    (ld_data)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    fault_d    = fault_q;
    ram_addr_d = ram_addr_q;
    ram_dina_d = ram_dina_q;
    ram_ena_d  = ram_ena_q;
    ram_wea_d  = ram_wea_q;
    axi_addr_d = axi_addr_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bready_d   = bready_q;
    case (state_q)
      IDLE: if (req_valid) begin
        cnt_d   = '0;
        rdata_d = req_addr;
        fault_d = 1'b0;
        state_d = DONE;
        if (!req_load && !req_store) begin
          state_d = DONE;
        end else if ((req_load && req_store) || misaligned(req_size, req_addr[1:0])) begin
          fault_d = 1'b1;
        end else if (req_addr[31:24] == MMIO_TAG) begin
          rdata_d    = '0;
          axi_addr_d = {req_addr[31:2], 2'b00};
          if (req_store) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            wdata_d   = st_data;
            wstrb_d   = st_strb;
            state_d   = AXI_AW_W;
          end else begin
            arvalid_d = 1'b1;
            state_d   = AXI_AR;
          end
        end else begin
          rdata_d    = '0;
          ram_ena_d  = 1'b1;
          ram_addr_d = req_addr[RAM_AW+1:2];
          ram_wea_d  = req_store ? st_strb : 4'b0000;
          ram_dina_d = req_store ? st_data : 32'h0;
          state_d    = RAM;
        end
      end
      // A store leaves after its single write cycle; a load waits out the read latency.
      RAM: begin
        cnt_d = cnt_q + 1'b1;
        if (ram_wea_q != 4'b0000 || cnt_q == CW'(RAM_LAT)) begin
          if (ram_wea_q == 4'b0000) rdata_d = ld_data;
          ram_ena_d = 1'b0;
          ram_wea_d = 4'b0000;
          state_d   = DONE;
        end
      end
      AXI_AW_W: begin
        cnt_d = cnt_q + 1'b1;
        if (awvalid_q && m_axi.awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi.wready) wvalid_d = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          cnt_d    = '0;
          state_d  = AXI_B;
        end else if (tmo_hit) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          fault_d   = 1'b1;
          state_d   = DONE;
        end
      end
      AXI_B: begin
        cnt_d = cnt_q + 1'b1;
        if (m_axi.bvalid || tmo_hit) begin
          bready_d = 1'b0;
          fault_d  = !m_axi.bvalid || (m_axi.bresp != RESP_OKAY);
          state_d  = DONE;
        end
      end
      AXI_AR: begin
        cnt_d = cnt_q + 1'b1;
        if (m_axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          cnt_d     = '0;
          state_d   = AXI_R;
        end else if (tmo_hit) begin
          arvalid_d = 1'b0;
          fault_d   = 1'b1;
          state_d   = DONE;
        end
      end
      AXI_R: begin
        cnt_d = cnt_q + 1'b1;
        if (m_axi.rvalid) begin
          rready_d = 1'b0;
          rdata_d  = ld_data;
          fault_d  = (m_axi.rresp != RESP_OKAY);
          state_d  = DONE;
        end else if (tmo_hit) begin
          rready_d = 1'b0;
          fault_d  = 1'b1;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rdata_q    <= '0;
      fault_q    <= 1'b0;
      ram_addr_q <= '0;
      ram_dina_q <= '0;
      ram_ena_q  <= 1'b0;
      ram_wea_q  <= 4'b0000;
      axi_addr_q <= '0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= 4'b0000;
      bready_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      fault_q    <= fault_d;
      ram_addr_q <= ram_addr_d;
      ram_dina_q <= ram_dina_d;
      ram_ena_q  <= ram_ena_d;
      ram_wea_q  <= ram_wea_d;
      axi_addr_q <= axi_addr_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bready_q   <= bready_d;
    end
  end

  // Load shaping info only matters after acceptance, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      ld_size_q <= req_size;
      ld_uns_q  <= req_unsigned;
      ld_off_q  <= req_addr[1:0];
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign done          = (state_q == DONE);
  assign fault         = fault_q;
  assign rdata         = rdata_q;
  assign ram_addr      = ram_addr_q;
  assign ram_dina      = ram_dina_q;
  assign ram_ena       = ram_ena_q;
  assign ram_wea       = ram_wea_q;
  assign m_axi.araddr  = axi_addr_q;
  assign m_axi.awaddr  = axi_addr_q;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.bready  = bready_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a byte-lane reference model and RAM shadow.
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int LAT = 2;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid, req_ready, req_load, req_store, req_unsigned;
  size_t       req_size;
  logic [31:0] req_addr, req_wdata;
  logic        done, fault;
  logic [31:0] rdata;
  logic [18:0] ram_addr;
  logic [31:0] ram_dina, ram_douta;
  logic        ram_ena;
  logic [3:0]  ram_wea;

  mem_access_unit_if m_axi();

  mem_access_unit #(.RAM_AW(19), .RAM_LAT(LAT), .MMIO_TAG(8'h7F), .TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_load(req_load), .req_store(req_store), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .done(done), .fault(fault), .rdata(rdata),
    .ram_addr(ram_addr), .ram_dina(ram_dina), .ram_douta(ram_douta),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .m_axi(m_axi)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: LAT register stages between issue and data.
  logic [31:0] mem [0:255];
  logic [31:0] rpipe [0:LAT-1];
  always @(posedge clk) begin
    for (int k = LAT - 1; k > 0; k--) rpipe[k] <= rpipe[k-1];
    if (ram_ena) begin
      rpipe[0] <= mem[ram_addr[7:0]];
      for (int b = 0; b < 4; b++)
        if (ram_wea[b]) mem[ram_addr[7:0]][8*b +: 8] = ram_dina[8*b +: 8];
    end
  end
  assign ram_douta = rpipe[LAT-1];

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] shadow [0:15];

  // Reference model from the byte-lane rules
  function automatic logic [31:0] exp_load(int sz, bit uns, int off, logic [31:0] w);
    int nb = 1 << sz;
    logic [31:0] v = 32'h0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = w[8*(off+i) +: 8];
    if (!uns && nb < 4 && v[8*nb-1])
      for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [3:0] exp_strb(int sz, int off);
    int nb = 1 << sz;
    logic [3:0] s = 4'h0;
    for (int i = 0; i < 4; i++) if (i >= off && i < off + nb) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] exp_wdata(int sz, logic [31:0] wd);
    int nb = 1 << sz;
    logic [31:0] d;
    for (int i = 0; i < 4; i++) d[8*i +: 8] = wd[8*(i % nb) +: 8];
    return d;
  endfunction

  function automatic bit exp_fault(bit ld, bit st, int sz, logic [31:0] a);
    return (ld && st) || sz == 3 || (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'b00);
  endfunction

  // Observations of the last transaction
  int          r_lat, r_ena_cyc, x_lat, x_ndone, x_last_ar;
  bit          r_bus, x_ar_at_done;
  logic [3:0]  r_wea, x_wstrb;
  logic [31:0] r_dina, x_wdata, x_awaddr, x_araddr, x_rdata;
  logic [18:0] r_addr;
  logic        x_fault;

  task automatic drive_req(input bit ld, input bit st, input int sz, input bit uns,
                           input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_load = ld; req_store = st; req_size = size_t'(2'(sz));
    req_unsigned = uns; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic run_req(input bit ld, input bit st, input int sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] wd);
    drive_req(ld, st, sz, uns, a, wd);
    r_lat = 0; r_ena_cyc = 0; r_bus = 0; r_wea = 4'h0; r_dina = 32'h0; r_addr = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin r_wea = ram_wea; r_dina = ram_dina; r_addr = ram_addr; end
      if (ram_ena) r_ena_cyc++;
      if (m_axi.arvalid || m_axi.awvalid || m_axi.wvalid) r_bus = 1;
      if (done) begin r_lat = c; break; end
    end
  endtask

  // AXI-lite slave: d_a delays AW/AR ready, d_b delays W ready / R valid.
  task automatic axi_xact(input bit ld, input bit st, input int sz, input bit uns,
                          input logic [31:0] a, input logic [31:0] wd, input int d_a, input int d_b,
                          input logic [31:0] sdata, input logic [1:0] resp, input int budget);
    drive_req(ld, st, sz, uns, a, wd);
    x_lat = 0; x_ndone = 0; x_last_ar = 0; x_ar_at_done = 0; x_fault = 1'b0;
    x_wstrb = 4'h0; x_wdata = 32'h0; x_awaddr = 32'h0; x_araddr = 32'h0; x_rdata = 32'h0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (m_axi.awvalid) x_awaddr = m_axi.awaddr;
      if (m_axi.wvalid) begin x_wdata = m_axi.wdata; x_wstrb = m_axi.wstrb; end
      if (m_axi.arvalid) begin x_araddr = m_axi.araddr; x_last_ar = c; end
      if (done) begin
        x_ndone++;
        if (x_lat == 0) begin
          x_lat = c; x_rdata = rdata; x_fault = fault; x_ar_at_done = m_axi.arvalid;
        end
      end
      m_axi.awready = m_axi.awvalid && c >= d_a;
      m_axi.wready  = m_axi.wvalid && c >= d_b;
      m_axi.bvalid  = m_axi.bready;
      m_axi.bresp   = resp;
      m_axi.arready = m_axi.arvalid && c >= d_a;
      m_axi.rvalid  = m_axi.rready && c >= d_b;
      m_axi.rdata   = sdata;
      m_axi.rresp   = resp;
    end
    m_axi.awready = 0; m_axi.wready = 0; m_axi.bvalid = 0;
    m_axi.arready = 0; m_axi.rvalid = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    n_tests++;
    if ({done, fault, ram_ena, ram_wea, m_axi.arvalid, m_axi.awvalid, m_axi.wvalid,
         m_axi.bready, m_axi.rready} !== 12'h000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0",
        {done, fault, ram_ena, ram_wea, m_axi.arvalid, m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.rready});
    end
    n_tests++;
    if (rdata !== 32'h0 || ram_addr !== 19'h0 || ram_dina !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: got rdata %h ram_addr %h dina %h want 0", rdata, ram_addr, ram_dina);
    end
  endtask

  task automatic test_ram_fill();
    for (int w = 0; w < 16; w++) begin
      shadow[w] = $urandom;
      run_req(0, 1, 2, 0, 32'(w * 4), shadow[w]);
      n_tests++;
      if (r_lat != 2 || r_wea !== 4'hF) begin
        n_fail++; $display("FAIL fill_sw[%0d]: got lat %0d wea %b want 2 1111", w, r_lat, r_wea);
      end
    end
  endtask

  task automatic test_store_byte();
    run_req(0, 1, 0, 0, 32'h0000_0103, 32'h0000_00AB);
    n_tests++;
    if (r_wea !== 4'b1000 || r_dina !== 32'hABABABAB || r_addr !== 19'h40) begin
      n_fail++; $display("FAIL sb_lanes: got wea %b dina %h addr %h want 1000 ABABABAB 40", r_wea, r_dina, r_addr);
    end
    n_tests++;
    if (r_lat != 2 || r_ena_cyc != 1) begin
      n_fail++; $display("FAIL sb_timing: got lat %0d ena_cycles %0d want 2 1", r_lat, r_ena_cyc);
    end
  endtask

  task automatic test_load_half();
    run_req(0, 1, 2, 0, 32'h0, 32'h80F41234);
    shadow[0] = 32'h80F41234;
    run_req(1, 0, 1, 0, 32'h2, 32'h0);
    n_tests++;
    if (rdata !== 32'hFFFF80F4 || r_lat != LAT + 2 || fault !== 1'b0) begin
      n_fail++; $display("FAIL lh: got %h lat %0d fault %b want FFFF80F4 %0d 0", rdata, r_lat, fault, LAT + 2);
    end
    run_req(1, 0, 1, 1, 32'h2, 32'h0);
    n_tests++;
    if (rdata !== 32'h000080F4 || r_lat != LAT + 2) begin
      n_fail++; $display("FAIL lhu: got %h lat %0d want 000080F4 %0d", rdata, r_lat, LAT + 2);
    end
  endtask

  task automatic test_fault_passthru();
    run_req(1, 0, 2, 0, 32'h0000_0006, 32'h0);
    n_tests++;
    if (fault !== 1'b1 || r_lat != 1 || r_ena_cyc != 0 || r_bus || rdata !== 32'h6) begin
      n_fail++; $display("FAIL lw_misalign: got fault %b lat %0d ena %0d bus %b rdata %h want 1 1 0 0 6",
                         fault, r_lat, r_ena_cyc, r_bus, rdata);
    end
    run_req(0, 0, 2, 0, 32'h7F00_1235, 32'h0);
    n_tests++;
    if (fault !== 1'b0 || r_lat != 1 || r_bus || rdata !== 32'h7F001235) begin
      n_fail++; $display("FAIL passthru: got fault %b lat %0d rdata %h want 0 1 7F001235", fault, r_lat, rdata);
    end
  endtask

  task automatic test_ram_random();
    for (int n = 0; n < 40; n++) begin
      int k = $urandom_range(0, 9);
      bit ld = (k == 1) || (k >= 2 && k < 6);
      bit st = (k == 1) || (k >= 6);
      int sz = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      bit uns = 1'($urandom_range(0, 1));
      int w = $urandom_range(0, 15);
      logic [31:0] a = {8'($urandom_range(0, 2)), 16'h0, 6'(w), 2'($urandom_range(0, 3))};
      logic [31:0] wd = $urandom;
      run_req(ld, st, sz, uns, a, wd);
      n_tests++;
      if (!ld && !st) begin
        if (r_lat != 1 || fault !== 1'b0 || rdata !== a)
          begin n_fail++; $display("FAIL rnd_pass[%0d]: got lat %0d fault %b rdata %h want 1 0 %h", n, r_lat, fault, rdata, a); end
      end else if (exp_fault(ld, st, sz, a)) begin
        if (r_lat != 1 || fault !== 1'b1 || rdata !== a || r_ena_cyc != 0)
          begin n_fail++; $display("FAIL rnd_fault[%0d]: got lat %0d fault %b rdata %h ena %0d want 1 1 %h 0", n, r_lat, fault, rdata, r_ena_cyc, a); end
      end else if (st) begin
        logic [3:0]  s = exp_strb(sz, int'(a[1:0]));
        logic [31:0] d = exp_wdata(sz, wd);
        if (r_lat != 2 || r_wea !== s || r_dina !== d || r_addr !== a[20:2])
          begin n_fail++; $display("FAIL rnd_store[%0d]: got lat %0d wea %b dina %h addr %h want 2 %b %h %h", n, r_lat, r_wea, r_dina, r_addr, s, d, a[20:2]); end
        for (int b = 0; b < 4; b++) if (s[b]) shadow[w][8*b +: 8] = d[8*b +: 8];
      end else begin
        logic [31:0] e = exp_load(sz, uns, int'(a[1:0]), shadow[w]);
        if (r_lat != LAT + 2 || rdata !== e || fault !== 1'b0)
          begin n_fail++; $display("FAIL rnd_load[%0d]: got lat %0d rdata %h fault %b want %0d %h 0", n, r_lat, rdata, fault, LAT + 2, e); end
      end
    end
  endtask

  task automatic test_axi_write();
    axi_xact(0, 1, 2, 0, 32'h7F00_0004, 32'h0000_0055, 4, 1, 32'h0, 2'b00, 14);
    n_tests++;
    if (x_awaddr !== 32'h7F000004 || x_wstrb !== 4'b1111 || x_wdata !== 32'h55) begin
      n_fail++; $display("FAIL sw_axi_bus: got awaddr %h wstrb %b wdata %h want 7F000004 1111 00000055", x_awaddr, x_wstrb, x_wdata);
    end
    n_tests++;
    if (x_ndone != 1 || x_fault !== 1'b0 || x_lat != 6) begin
      n_fail++; $display("FAIL sw_axi_done: got dones %0d fault %b lat %0d want 1 0 6", x_ndone, x_fault, x_lat);
    end
  endtask

  task automatic test_axi_read_err();
    axi_xact(1, 0, 0, 1, 32'h7F00_0001, 32'h0, 1, 1, 32'h0000_C300, RESP_SLVERR, 12);
    n_tests++;
    if (x_rdata !== 32'h000000C3 || x_fault !== 1'b1 || x_ndone != 1 || x_araddr !== 32'h7F000000) begin
      n_fail++; $display("FAIL lbu_axi: got rdata %h fault %b dones %0d araddr %h want 000000C3 1 1 7F000000",
                         x_rdata, x_fault, x_ndone, x_araddr);
    end
  endtask

  task automatic test_axi_timeout();
    axi_xact(1, 0, 2, 0, 32'h7F00_0010, 32'h0, 100000, 1, 32'h0, 2'b00, TMO + 8);
    n_tests++;
    if (x_fault !== 1'b1 || x_ndone != 1 || x_lat < TMO || x_lat > TMO + 2) begin
      n_fail++; $display("FAIL ar_timeout: got fault %b dones %0d lat %0d want 1 1 %0d..%0d", x_fault, x_ndone, x_lat, TMO, TMO + 2);
    end
    n_tests++;
    if (x_ar_at_done !== 1'b0 || x_last_ar < TMO - 1) begin
      n_fail++; $display("FAIL ar_timeout_valid: got arvalid_at_done %b last_ar %0d want 0 >=%0d", x_ar_at_done, x_last_ar, TMO - 1);
    end
  endtask

  task automatic test_axi_random();
    for (int n = 0; n < 12; n++) begin
      bit st = 1'($urandom_range(0, 1));
      int sz = $urandom_range(0, 2);
      bit uns = 1'($urandom_range(0, 1));
      int off = (sz == 0) ? $urandom_range(0, 3) : (sz == 1) ? 2 * $urandom_range(0, 1) : 0;
      logic [31:0] a = {8'h7F, 16'($urandom), 6'($urandom), 2'(off)};
      logic [31:0] wd = $urandom;
      logic [31:0] sd = $urandom;
      logic [1:0] resp = ($urandom_range(0, 2) == 0) ? RESP_SLVERR : RESP_OKAY;
      axi_xact(!st, st, sz, uns, a, wd, $urandom_range(0, 4), $urandom_range(0, 4), sd, resp, 16);
      n_tests++;
      if (x_ndone != 1 || x_fault !== (resp != 2'b00)) begin
        n_fail++; $display("FAIL axi_rnd_done[%0d]: got dones %0d fault %b want 1 %b", n, x_ndone, x_fault, resp != 2'b00);
      end
      n_tests++;
      if (st) begin
        if (x_awaddr !== {a[31:2], 2'b00} || x_wstrb !== exp_strb(sz, off) || x_wdata !== exp_wdata(sz, wd)) begin
          n_fail++; $display("FAIL axi_rnd_wr[%0d]: got %h %b %h want %h %b %h", n, x_awaddr, x_wstrb, x_wdata,
                             {a[31:2], 2'b00}, exp_strb(sz, off), exp_wdata(sz, wd));
        end
      end else if (x_araddr !== {a[31:2], 2'b00} || x_rdata !== exp_load(sz, uns, off, sd)) begin
        n_fail++; $display("FAIL axi_rnd_rd[%0d]: got %h %h want %h %h", n, x_araddr, x_rdata,
                           {a[31:2], 2'b00}, exp_load(sz, uns, off, sd));
      end
    end
  endtask

  task automatic test_reset_mid_axi();
    bit seen_b = 0;
    int ndone = 0;
    drive_req(0, 1, 2, 0, 32'h7F00_0008, 32'hDEAD_BEEF);
    for (int c = 1; c <= 10 && !seen_b; c++) begin
      @(negedge clk);
      if (m_axi.bready) seen_b = 1;
      m_axi.awready = m_axi.awvalid;
      m_axi.wready  = m_axi.wvalid;
    end
    m_axi.awready = 0; m_axi.wready = 0;
    n_tests++;
    if (!seen_b) begin n_fail++; $display("FAIL rst_reach_b: got bready 0 want 1 within 10 cycles"); end
    rstn = 1'b0;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1 || done !== 1'b0 || fault !== 1'b0 || rdata !== 32'h0 ||
        m_axi.bready !== 1'b0 || m_axi.awvalid !== 1'b0 || m_axi.wvalid !== 1'b0 ||
        m_axi.awaddr !== 32'h0 || m_axi.wdata !== 32'h0 || m_axi.wstrb !== 4'h0 || ram_ena !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_b: got ready %b done %b fault %b bready %b awaddr %h wdata %h wstrb %b want 1 0 0 0 0 0 0",
                         req_ready, done, fault, m_axi.bready, m_axi.awaddr, m_axi.wdata, m_axi.wstrb);
    end
    rstn = 1'b1;
    m_axi.bvalid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    m_axi.bvalid = 1'b0;
    n_tests++;
    if (ndone != 0) begin n_fail++; $display("FAIL rst_no_done: got %0d done pulses want 0", ndone); end
  endtask

  initial begin
    req_valid = 0; req_load = 0; req_store = 0; req_size = SZ_BYTE; req_unsigned = 0;
    req_addr = 0; req_wdata = 0;
    m_axi.arready = 0; m_axi.rdata = 0; m_axi.rresp = 0; m_axi.rvalid = 0;
    m_axi.awready = 0; m_axi.wready = 0; m_axi.bresp = 0; m_axi.bvalid = 0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    rstn = 1'b1;
    test_ram_fill();
    test_store_byte();
    test_load_half();
    test_fault_passthru();
    test_ram_random();
    test_axi_write();
    test_axi_read_err();
    test_axi_timeout();
    test_axi_random();
    test_reset_mid_axi();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
